core_id_alu_dec: RTL
====================

Name: core_id_alu_dec

Overview:
- ID-stage producer of the ALU instruction bus.
- Decodes one RV32I instruction word into `CORE_ALU_INST_WIDTH-bit alu_inst_bus, a sign-extended immediate and register addresses.
- Registers the result into a 2-entry output buffer (output register plus skid) with valid/ready handshakes on both sides, so the EX-stage ALU receives a registered, stall-safe decode packet.

Parameters:
- XLEN, `CORE_XLEN (32): pc and immediate width.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  synchronous pipeline flush (branch/exception).
- in_valid  in  1  fetch packet valid.
- in_ready  out  1  decoder can accept; registered.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction pc.
- out_valid  out  1  decode packet valid.
- out_ready  in  1  EX accepts packet.
- out_alu_inst_bus  out  `CORE_ALU_INST_WIDTH  one-hot op bits, OP1_PC, OP2_IMM and RS2ADR field, laid out by the `CORE_ALU_INST_* defines.
- out_imm  out  XLEN  sign-extended immediate.
- out_pc  out  XLEN  pc of the packet.
- out_rs1_addr  out  5  source 1 address.
- out_rs2_addr  out  5  source 2 address.
- out_rd_addr  out  5  destination address.
- out_rd_wen  out  1  rd write enable.
- out_illegal  out  1  undecodable instruction.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Both buffer entries are invalid.
- Decode is combinational on in_inst. The packet is captured on an in_valid & in_ready edge. Latency is 1 cycle from accept to out_valid. Throughput is 1 per cycle while out_ready=1.
- Decode table:
  - OP (0110011):
    - funct3 000: ADD, or SUB if funct7[5]=1.
    - 001 SLL; 010 CMP; 011 CMP_U; 100 XOR.
    - 101: SRL, or SRA if funct7[5]=1.
    - 110 OR; 111 AND.
    - rd_wen=1.
  - OP-IMM (0010011): same mapping plus OP2_IMM. No SUB: funct3 000 is always ADD. I-immediate.
  - LUI: ADD + OP2_IMM, rs1_addr forced to 0, U-immediate.
  - AUIPC: ADD + OP1_PC + OP2_IMM, U-immediate.
  - JAL / JALR: ADD + OP1_PC, OP2_IMM=0 so the ALU yields pc+4. imm = J/I-immediate for the target. rd_wen=1.
  - BRANCH:
    - funct3 000/001 (BEQ/BNE): SUB bit (EX uses zero_flag).
    - 100/101: CMP.
    - 110/111: CMP_U.
    - B-immediate, rd_wen=0.
  - LOAD: ADD + OP2_IMM, I-immediate, rd_wen=1.
  - STORE: ADD + OP2_IMM, S-immediate, rd_wen=0.
  - Any other opcode, or inst[1:0]!=11: bus=0, imm=0, rd_wen=0, illegal=1. The packet still flows so EX can trap.
- rd_wen is forced 0 when rd_addr=0.
- The RS2ADR field always carries inst[24:20] (the shamt for immediate shifts).
- Buffer, entry A (output) and entry B (skid):
  - in_ready = !B_valid, registered.
  - Accept with A empty, or with A draining in the same cycle: write A.
  - Accept with A full and not draining: write B.
  - A drains (out_valid & out_ready) while B is valid: B moves to A, B is cleared.
  - Simultaneous drain of A and accept while B is valid cannot occur, because in_ready=0.
  - Packet order is strictly preserved. No packet is dropped or duplicated.
- flush: in the next cycle A_valid=B_valid=0 and in_ready=1. An accept in the flush cycle is discarded; flush has priority.
- Async rst mid-stream: out_valid drops immediately and buffered packets are lost.
- Payload registers hold their values when the entry is not written. Only the valid bits need reset.

Test Plan:
- add x3,x1,x2 (0x002081B3), pc=0x100, out_ready=1 → next cycle out_valid=1, ADD only, rs1=1, rs2=2, rd=3, rd_wen=1, pc=0x100.
- srai x5,x6,7 (0x40735293) → SRA+OP2_IMM, RS2ADR=7, imm=0x00000407, rd=5.
- auipc x1,0x12345 (0x12345097), pc=0x80000000 → ADD+OP1_PC+OP2_IMM, imm=0x12345000.
- out_ready=0, three back-to-back valid instructions → first two accepted, in_ready=0 on the third. out_ready=1 → packets emerge in order on consecutive cycles, then the third is accepted.
- Both entries full, flush=1 with in_valid=1 → next cycle out_valid=0, in_ready=1, and the flush-cycle instruction never appears.
- in_inst=0xFFFFFFFF → out_illegal=1, bus=0, rd_wen=0. Also: addi x0,x0,1 → rd_wen=0. Also: rst during out_valid=1 → out_valid=0 with no clock edge.

Source files
------------

// File: rtl/core_id_alu_dec.sv
// ID-stage RV32I decoder producing the ALU instruction bus, registered through
// a two-entry (output + skid) valid/ready buffer.
`timescale 1ns/1ps

`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_ALU_INST_WIDTH
`define CORE_ALU_INST_ADD        0
`define CORE_ALU_INST_SUB        1
`define CORE_ALU_INST_SLL        2
`define CORE_ALU_INST_CMP        3
`define CORE_ALU_INST_CMP_U      4
`define CORE_ALU_INST_XOR        5
`define CORE_ALU_INST_SRL        6
`define CORE_ALU_INST_SRA        7
`define CORE_ALU_INST_OR         8
`define CORE_ALU_INST_AND        9
`define CORE_ALU_INST_OP1_PC     10
`define CORE_ALU_INST_OP2_IMM    11
`define CORE_ALU_INST_RS2ADR_LSB 12
`define CORE_ALU_INST_RS2ADR_MSB 16
`define CORE_ALU_INST_WIDTH      17
`endif

module core_id_alu_dec #(
  parameter int unsigned XLEN = `CORE_XLEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [31:0]                     in_inst,
  input  logic [XLEN-1:0]                 in_pc,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [`CORE_ALU_INST_WIDTH-1:0] out_alu_inst_bus,
  output logic [XLEN-1:0]                 out_imm,
  output logic [XLEN-1:0]                 out_pc,
  output logic [4:0]                      out_rs1_addr,
  output logic [4:0]                      out_rs2_addr,
  output logic [4:0]                      out_rd_addr,
  output logic                            out_rd_wen,
  output logic                            out_illegal
);

  localparam int unsigned BW = `CORE_ALU_INST_WIDTH;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [BW-1:0]   bus;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_wen;
    logic            illegal;
  } pkt_t;

  // One-hot ALU op for the shared OP / OP-IMM funct3 mapping.
  function automatic logic [BW-1:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [BW-1:0] s;
    s = '0;
    case (f3)
      3'b000: if (alt) s[`CORE_ALU_INST_SUB] = 1'b1; else s[`CORE_ALU_INST_ADD] = 1'b1;
      3'b001: s[`CORE_ALU_INST_SLL]   = 1'b1;
      3'b010: s[`CORE_ALU_INST_CMP]   = 1'b1;
      3'b011: s[`CORE_ALU_INST_CMP_U] = 1'b1;
      3'b100: s[`CORE_ALU_INST_XOR]   = 1'b1;
      3'b101: if (alt) s[`CORE_ALU_INST_SRA] = 1'b1; else s[`CORE_ALU_INST_SRL] = 1'b1;
      3'b110: s[`CORE_ALU_INST_OR]    = 1'b1;
      default: s[`CORE_ALU_INST_AND]  = 1'b1;
    endcase
    return s;
  endfunction

  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [31:0]   imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u  = {in_inst[31:12], 12'b0};
  assign imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  logic [BW-1:0] alu_bits;
  logic [BW-1:0] bus;
  logic [31:0]   imm32;
  logic          op1_pc, op2_imm, wen, legal, rs1_zero;
  pkt_t          dec_pkt;

  always_comb begin
    alu_bits = '0;
    imm32    = '0;
    op1_pc   = 1'b0;
    op2_imm  = 1'b0;
    wen      = 1'b0;
    legal    = 1'b1;
    rs1_zero = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_bits = alu_sel(funct3, in_inst[30]);
        wen      = 1'b1;
      end
      OPC_OP_IMM: begin
        // Only shifts use funct7[5]; addi never becomes a subtract.
        alu_bits = alu_sel(funct3, (funct3 == 3'b101) && in_inst[30]);
        op2_imm  = 1'b1;
        wen      = 1'b1;
        imm32    = imm_i;
      end
      OPC_LUI: begin
        alu_bits[`CORE_ALU_INST_ADD] = 1'b1;
        op2_imm  = 1'b1;
        wen      = 1'b1;
        rs1_zero = 1'b1;
        imm32    = imm_u;
      end
      OPC_AUIPC: begin
        alu_bits[`CORE_ALU_INST_ADD] = 1'b1;
        op1_pc   = 1'b1;
        op2_imm  = 1'b1;
        wen      = 1'b1;
        imm32    = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        alu_bits[`CORE_ALU_INST_ADD] = 1'b1;
        op1_pc   = 1'b1;
        wen      = 1'b1;
        imm32    = (opcode == OPC_JAL) ? imm_j : imm_i;
      end
      OPC_BRANCH: begin
        imm32 = imm_b;
        case (funct3)
          3'b000, 3'b001: alu_bits[`CORE_ALU_INST_SUB]   = 1'b1;
          3'b100, 3'b101: alu_bits[`CORE_ALU_INST_CMP]   = 1'b1;
          3'b110, 3'b111: alu_bits[`CORE_ALU_INST_CMP_U] = 1'b1;
          default:        legal = 1'b0;
        endcase
      end
      OPC_LOAD, OPC_STORE: begin
        alu_bits[`CORE_ALU_INST_ADD] = 1'b1;
        op2_imm  = 1'b1;
        wen      = (opcode == OPC_LOAD);
        imm32    = (opcode == OPC_LOAD) ? imm_i : imm_s;
      end
      default: legal = 1'b0;
    endcase

    bus = alu_bits;
    bus[`CORE_ALU_INST_OP1_PC]  = op1_pc;
    bus[`CORE_ALU_INST_OP2_IMM] = op2_imm;
    bus[`CORE_ALU_INST_RS2ADR_MSB:`CORE_ALU_INST_RS2ADR_LSB] = in_inst[24:20];

    dec_pkt.bus     = legal ? bus : '0;
    dec_pkt.imm     = legal ? XLEN'($signed(imm32)) : '0;
    dec_pkt.pc      = in_pc;
    dec_pkt.rs1     = rs1_zero ? 5'd0 : in_inst[19:15];
    dec_pkt.rs2     = in_inst[24:20];
    dec_pkt.rd      = in_inst[11:7];
    dec_pkt.rd_wen  = legal && wen && (in_inst[11:7] != 5'd0);
    dec_pkt.illegal = !legal;
  end

  pkt_t a_q, a_d, b_q, b_d;
  logic a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic in_ready_q, in_ready_d;
  logic accept, drain;

  assign accept = in_valid && in_ready_q;
  assign drain  = a_valid_q && out_ready;

  // Output/skid buffer next state; flush overrides everything.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    a_valid_d = a_valid_q;
    b_valid_d = b_valid_q;
    if (flush) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end else if (drain) begin
      if (b_valid_q) begin
        a_d       = b_q;
        b_valid_d = 1'b0;
      end else if (accept) begin
        a_d       = dec_pkt;
      end else begin
        a_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (a_valid_q) begin
        b_d       = dec_pkt;
        b_valid_d = 1'b1;
      end else begin
        a_d       = dec_pkt;
        a_valid_d = 1'b1;
      end
    end
    in_ready_d = !b_valid_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q        <= '0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      a_q        <= a_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Skid payload needs no reset; its valid bit guards it.
  always_ff @(posedge clk) begin
    b_q <= b_d;
  end

  assign in_ready         = in_ready_q;
  assign out_valid        = a_valid_q;
  assign out_alu_inst_bus = a_q.bus;
  assign out_imm          = a_q.imm;
  assign out_pc           = a_q.pc;
  assign out_rs1_addr     = a_q.rs1;
  assign out_rs2_addr     = a_q.rs2;
  assign out_rd_addr      = a_q.rd;
  assign out_rd_wen       = a_q.rd_wen;
  assign out_illegal      = a_q.illegal;

endmodule
